pc_fetch_sequencer: RTL

Fetch/sequence stage directly downstream of the 8-bit program counter. It reads a 32×8 instruction store at the counter value and executes a tiny control ISA. It drives the counter's enable, load and load-value inputs to advance, jump, stall or halt, and emits data bytes to the output stage. It is a two-stage design (fetch, execute), with a one-bubble flush on taken jumps.

---
 rtl/pc_fetch_sequencer_if.sv | 26 ++
 rtl/pc_fetch_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Signal bundle between the fetch/sequence stage, its program counter,
// the instruction-store loader and the output stage.
interface pc_fetch_sequencer_if;
  logic [7:0] pc;
  logic       pc_en;
  logic       pc_load;
  logic [7:0] pc_load_val;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic       go;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;

  // master: the sequencer, which steers the counter and drives the output stage
  modport master (
    input  pc, prog_we, prog_addr, prog_data, go,
    output pc_en, pc_load, pc_load_val, out_data, out_valid, halted
  );

  modport slave (
    output pc, prog_we, prog_addr, prog_data, go,
    input  pc_en, pc_load, pc_load_val, out_data, out_valid, halted
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Two-stage fetch/execute sequencer for a tiny control ISA; steers the
// external program counter and emits OUT bytes to the output stage.
module pc_fetch_sequencer #(
  parameter int MEM_DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pc_fetch_sequencer_if.master   bus
);
  localparam int AW = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP, OP_JMP, OP_SETLC, OP_DJNZ, OP_OUT, OP_WAIT, OP_HALT, OP_RSVD
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [4:0] imm;
  } instr_t;

  typedef enum logic [1:0] {HALTED, RUN, STALL} state_e;

  logic [7:0] mem [MEM_DEPTH];

  state_e     state, state_nxt;
  instr_t     ir, ir_nxt, fetch;
  logic       ir_valid, ir_valid_nxt;
  logic [4:0] lc, lc_nxt;
  logic [4:0] wcnt, wcnt_nxt;
  logic [7:0] out_data_q, out_data_nxt;
  logic       out_valid_q, out_valid_nxt;
  logic       pc_en, pc_load, taken, halted;
  logic [7:0] pc_load_val;

  // pc values above the store depth alias onto it
  logic unused_pc_hi;
  assign unused_pc_hi = ^bus.pc[7:AW];

  // Store is not reset; a same-cycle read of the written address sees old data
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  assign fetch = instr_t'(mem[bus.pc[AW-1:0]]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HALTED;
      ir          <= '0;
      ir_valid    <= 1'b0;
      lc          <= '0;
      wcnt        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      ir          <= ir_nxt;
      ir_valid    <= ir_valid_nxt;
      lc          <= lc_nxt;
      wcnt        <= wcnt_nxt;
      out_data_q  <= out_data_nxt;
      out_valid_q <= out_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ir_nxt        = ir;
    ir_valid_nxt  = ir_valid;
    lc_nxt        = lc;
    wcnt_nxt      = wcnt;
    out_data_nxt  = out_data_q;
    out_valid_nxt = 1'b0;
    pc_en         = 1'b0;
    pc_load       = 1'b0;
    pc_load_val   = '0;
    taken         = 1'b0;
    halted        = 1'b0;
    case (state)
      HALTED: begin
        halted = 1'b1;
        if (bus.go) begin
          state_nxt    = RUN;
          ir_valid_nxt = 1'b0;
        end
      end
      RUN: begin
        pc_en = 1'b1;
        if (ir_valid) begin
          case (ir.op)
            OP_JMP:   taken = 1'b1;
            OP_SETLC: lc_nxt = ir.imm;
            OP_DJNZ:  if (lc != 5'd0) begin
                        taken  = 1'b1;
                        lc_nxt = lc - 5'd1;
                      end
            OP_OUT:   begin
                        out_data_nxt  = {3'b000, ir.imm};
                        out_valid_nxt = 1'b1;
                      end
            // the WAIT cycle still fetches, so the next instruction waits in IR
            OP_WAIT:  if (ir.imm != 5'd0) begin
                        wcnt_nxt  = ir.imm;
                        state_nxt = STALL;
                      end
            OP_HALT:  begin
                        pc_en        = 1'b0;
                        ir_valid_nxt = 1'b0;
                        state_nxt    = HALTED;
                      end
            default: ;
          endcase
        end
        // taken jump: load counter, no fetch, next cycle is a bubble
        if (taken) begin
          pc_en        = 1'b0;
          pc_load      = 1'b1;
          pc_load_val  = {3'b000, ir.imm};
          ir_valid_nxt = 1'b0;
        end
        if (pc_en) begin
          ir_nxt       = fetch;
          ir_valid_nxt = 1'b1;
        end
      end
      STALL: begin
        wcnt_nxt = wcnt - 5'd1;
        if (wcnt == 5'd1) state_nxt = RUN;
      end
      default: state_nxt = HALTED;
    endcase
  end

  assign bus.pc_en       = pc_en;
  assign bus.pc_load     = pc_load;
  assign bus.pc_load_val = pc_load_val;
  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.halted      = halted;
endmodule
